// File: rtl/uart_cmd_decoder.sv
// Turns UART keystrokes (single keys and ESC [ X arrow sequences) into game commands.
// Commands reach cmd_valid 1 cycle after the completing byte; a push into a full FIFO without a pop is dropped and sets overflow.
module uart_cmd_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       received,
  input  logic [7:0] rx_byte,
  input  logic       recv_error,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  input  logic       cmd_ready,
  output logic       overflow,
  output logic [7:0] err_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [16:0] TMO_LAST = 17'(TIMEOUT - 1);

  localparam logic [2:0] CMD_LEFT    = 3'd1;
  localparam logic [2:0] CMD_RIGHT   = 3'd2;
  localparam logic [2:0] CMD_DOWN    = 3'd3;
  localparam logic [2:0] CMD_ROTATE  = 3'd4;
  localparam logic [2:0] CMD_PAUSE   = 3'd5;
  localparam logic [2:0] CMD_RESTART = 3'd6;

  typedef enum logic [1:0] {IDLE, GOT_ESC, GOT_BRKT} state_t;

  state_t      state, state_nxt;
  logic [16:0] tmo_cnt;
  logic        push;
  logic [2:0]  push_cmd;

  logic [2:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, pop, wr_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (received || recv_error || state == IDLE)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 17'd1;
    end
  end

  // A byte arriving on the timeout cycle is still decoded in the current state.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_cmd  = 3'd0;
    if (recv_error) begin
      state_nxt = IDLE;
    end else if (received) begin
      case (state)
        IDLE: begin
          case (rx_byte)
            8'h61, 8'h41: begin push = 1'b1; push_cmd = CMD_LEFT;    end
            8'h64, 8'h44: begin push = 1'b1; push_cmd = CMD_RIGHT;   end
            8'h73, 8'h53: begin push = 1'b1; push_cmd = CMD_DOWN;    end
            8'h77, 8'h57: begin push = 1'b1; push_cmd = CMD_ROTATE;  end
            8'h70, 8'h50: begin push = 1'b1; push_cmd = CMD_PAUSE;   end
            8'h72, 8'h52: begin push = 1'b1; push_cmd = CMD_RESTART; end
            8'h1B:        state_nxt = GOT_ESC;
            default:      state_nxt = IDLE;
          endcase
        end
        GOT_ESC: begin
          if (rx_byte == 8'h5B)      state_nxt = GOT_BRKT;
          else if (rx_byte == 8'h1B) state_nxt = GOT_ESC;
          else                       state_nxt = IDLE;
        end
        GOT_BRKT: begin
          state_nxt = IDLE;
          case (rx_byte)
            8'h41:   begin push = 1'b1; push_cmd = CMD_ROTATE; end
            8'h42:   begin push = 1'b1; push_cmd = CMD_DOWN;   end
            8'h43:   begin push = 1'b1; push_cmd = CMD_RIGHT;  end
            8'h44:   begin push = 1'b1; push_cmd = CMD_LEFT;   end
            default: push = 1'b0;
          endcase
        end
        default: state_nxt = IDLE;
      endcase
    end else if (state != IDLE && tmo_cnt == TMO_LAST) begin
      state_nxt = IDLE;
    end
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_valid = !empty;
  assign cmd       = empty ? 3'd0 : mem[rd_ptr[AW-1:0]];
  assign pop       = cmd_valid && cmd_ready;
  assign wr_en     = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr[AW-1:0]] <= push_cmd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      err_count <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop)
        overflow <= 1'b1;
      if (recv_error && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
Consumes the byte stream from the UART receiver (received / rx_byte / recv_error) and translates keyboard input into game commands for the Falling Cubes control logic. It recognises single ASCII keys and 3-byte ANSI arrow-key escape sequences (ESC '[' X). Decoded commands are buffered in a small FIFO and handed to the game FSM over a valid/ready handshake.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2.
TIMEOUT, 100000, clk cycles an incomplete escape sequence may wait for its next byte (1 ms at 100 MHz).

Ports:
clk  input  1  master clock, 100 MHz.
rst  input  1  reset, asynchronous, active-low.
received  input  1  one-cycle pulse: rx_byte is valid.
rx_byte  input  8  received byte.
recv_error  input  1  one-cycle pulse: framing or start-bit error.
cmd_valid  output  1  FIFO non-empty; cmd is valid.
cmd  output  3  head command: 1=LEFT 2=RIGHT 3=DOWN 4=ROTATE 5=PAUSE 6=RESTART (0 and 7 never emitted).
cmd_ready  input  1  consumer accepts cmd when cmd_valid=1.
overflow  output  1  sticky: a command was dropped because the FIFO was full.
err_count  output  8  recv_error pulses seen, saturating at 255.

Behaviour:
- Reset (rst=0, asynchronous): parser state = IDLE, FIFO empty, timeout counter = 0. Outputs: cmd_valid=0, cmd=0, overflow=0, err_count=0. Only reset clears overflow.
- Parser FSM states: IDLE, GOT_ESC, GOT_BRKT. It advances only on cycles with received=1.
- IDLE, single-byte keys (case-insensitive):
  - 'a'/'A' (0x61/0x41) → LEFT; 'd'/'D' → RIGHT; 's'/'S' → DOWN.
  - 'w'/'W' → ROTATE; 'p'/'P' → PAUSE; 'r'/'R' → RESTART.
  - 0x1B → GOT_ESC, no push.
  - Any other byte is discarded silently; no push.
- GOT_ESC:
  - 0x5B '[' → GOT_BRKT.
  - 0x1B → stay in GOT_ESC.
  - Any other byte → IDLE; that byte is discarded, not re-decoded.
- GOT_BRKT:
  - 'A' → ROTATE, 'B' → DOWN, 'C' → RIGHT, 'D' → LEFT; then IDLE.
  - Any other byte → IDLE, no push.
- Timeout counter:
  - Cleared on every received pulse and while in IDLE; increments each cycle otherwise.
  - On reaching TIMEOUT-1 in GOT_ESC or GOT_BRKT → IDLE, no push. A lone ESC therefore produces nothing.
- recv_error=1:
  - Parser → IDLE and timeout counter cleared.
  - err_count increments, saturating at 255.
  - If received and recv_error are both 1 in the same cycle, the error wins and the byte is ignored.
- Push timing:
  - A decode completes on the clk edge where received=1. The command is written into the FIFO at that edge.
  - cmd_valid rises on the next cycle. Latency from received to cmd_valid is 1 cycle.
- Pop: occurs at the edge where cmd_valid=1 and cmd_ready=1; cmd shows the next entry on the following cycle. cmd holds its value while cmd_valid=1 and cmd_ready=0.
- FIFO rules:
  - Order is strictly preserved.
  - When the FIFO is empty, cmd=0.
  - Simultaneous push and pop while full: both occur, and occupancy stays FULL.
  - Simultaneous push and pop while holding 1 entry: cmd_valid stays 1 and the new entry becomes head.
  - Push while full with no pop: the command is dropped, overflow is set to 1, and the FIFO is unchanged.
- Registers: pointers are log2(FIFO_DEPTH) bits wide plus one wrap bit for the full/empty decision. The timeout counter is 17 bits.

Test Plan:
1. Reset, then bytes 0x61, 0x44, 0x77, each as a 1-cycle received pulse, cmd_ready=1 → cmd_valid pulses 1 cycle after each pulse with cmd=1, 2, 4 in that order; FIFO empty afterwards.
2. Sequence 0x1B, 0x5B, 0x43, bytes 20 cycles apart → exactly one command, cmd=2 (RIGHT), 1 cycle after the 0x43 pulse; no output for the first two bytes.
3. 0x1B, then nothing for TIMEOUT+10 cycles, then 0x41 → only cmd=1 (LEFT) is emitted. Repeat with 0x1B, 0x5B, 0x41 and a TIMEOUT gap before the 0x41 → the 0x41 decodes as 'A' = LEFT.
4. cmd_ready=0; push 5 commands (r, p, s, a, d) → cmd_valid=1, head cmd=6, overflow=1 after the 5th. Then drain with cmd_ready=1 → 6, 5, 3, 1; the 'd' is lost.
5. FIFO full; received pulse in the same cycle as cmd_valid&cmd_ready → push and pop both occur, overflow stays 0, and the new command appears last.
6. Three recv_error pulses, one coinciding with received=1 byte 0x61, plus an error in GOT_BRKT followed by 0x43 → err_count=3, no commands emitted. Assert rst=0 mid-stream with the FIFO non-empty → cmd_valid, overflow and err_count all go to 0 immediately, without waiting for a clock edge.
